// File: rtl/fifo_traffic_checker_if.sv
// FIFO-side handshake bundle: write port, read port and the FIFO status flags.
interface fifo_traffic_checker_if #(
  parameter int DW = 128
);
  logic          wen;
  logic [DW-1:0] wdata;
  logic          ren;
  logic          full;
  logic          empty;
  logic [DW-1:0] rdata;

  modport master (output wen, wdata, ren, input full, empty, rdata);
  modport slave  (input wen, wdata, ren, output full, empty, rdata);
endinterface

// File: rtl/fifo_traffic_checker.sv
// Traffic generator and checker for a single-clock FIFO.
// Writes a counter or LFSR pattern, reads it back after RD_LAT cycles and
// compares against an independently advanced copy of the same generator.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   RUN    | writing, reading and checking; watchdog armed
//   DONE   | run finished; counters and pass/timeout held until next start
module fifo_traffic_checker #(
  parameter int          DW      = 128,
  parameter int          CNT_W   = 32,
  parameter int          RD_LAT  = 1,
  parameter int          TIMEOUT = 4096,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   mode,
  input  logic [CNT_W-1:0]       num_words,
  input  logic [3:0]             wr_gap,
  input  logic [3:0]             rd_gap,
  fifo_traffic_checker_if.master fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [CNT_W-1:0]       wr_count,
  output logic [CNT_W-1:0]       rd_count,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       first_err_idx
);
  localparam int LANES = DW / 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic             mode_q;
  logic [CNT_W-1:0] num_q;
  logic [3:0]       wr_gap_q, rd_gap_q;
  logic [3:0]       wr_gap_cnt, rd_gap_cnt;
  logic [CNT_W-1:0] rd_issued;
  logic [31:0]      wr_lfsr, exp_lfsr;
  logic [31:0]      wd_cnt;
  logic [3:0]       ren_dly;
  logic             timeout_q;

  logic             wen_i, ren_i, chk, last_chk, wd_fire;
  logic [4:0]       ren_taps;
  logic [DW-1:0]    exp_word;

  // Galois LFSR, x^32+x^22+x^2+x+1, right-shifting form.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Word pattern: lane k is n+k (counter) or L(n)^k (LFSR).
  function automatic logic [DW-1:0] pattern(input logic m, input logic [CNT_W-1:0] n,
                                            input logic [31:0] l);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++)
      w[k*32 +: 32] = m ? (l ^ 32'(k)) : (32'(n) + 32'(k));
    return w;
  endfunction

  // Handshakes are combinational so full/empty are honoured in the same cycle.
  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign timeout = timeout_q;
  assign pass    = done & ~timeout_q & (err_count == '0);

  assign wen_i = busy & ~fifo.full  & (wr_count  < num_q) & (wr_gap_cnt == 4'd0);
  assign ren_i = busy & ~fifo.empty & (rd_issued < num_q) & (rd_gap_cnt == 4'd0);

  assign fifo.wen   = wen_i;
  assign fifo.ren   = ren_i;
  assign fifo.wdata = busy ? pattern(mode_q, wr_count, wr_lfsr) : '0;

  // Tap 0 is the live ren, so RD_LAT=0 compares in the issuing cycle.
  assign ren_taps = {ren_dly, ren_i};
  assign chk      = busy & ren_taps[RD_LAT];
  assign exp_word = pattern(mode_q, rd_count, exp_lfsr);
  assign last_chk = chk & ((rd_count + CNT_W'(1)) == num_q);
  assign wd_fire  = busy & ~wen_i & ~ren_i & (wd_cnt == 32'd0);

  // Sequencer, generators, check pipeline and watchdog.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      mode_q        <= 1'b0;
      num_q         <= '0;
      wr_gap_q      <= '0;
      rd_gap_q      <= '0;
      wr_gap_cnt    <= '0;
      rd_gap_cnt    <= '0;
      wr_count      <= '0;
      rd_count      <= '0;
      rd_issued     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      wr_lfsr       <= SEED;
      exp_lfsr      <= SEED;
      wd_cnt        <= 32'(TIMEOUT - 1);
      ren_dly       <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= (num_words == '0) ? S_DONE : S_RUN;
            mode_q        <= mode;
            num_q         <= num_words;
            wr_gap_q      <= wr_gap;
            rd_gap_q      <= rd_gap;
            wr_gap_cnt    <= '0;
            rd_gap_cnt    <= '0;
            wr_count      <= '0;
            rd_count      <= '0;
            rd_issued     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            wr_lfsr       <= SEED;
            exp_lfsr      <= SEED;
            wd_cnt        <= 32'(TIMEOUT - 1);
            ren_dly       <= '0;
            timeout_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (wen_i) begin
            wr_count   <= wr_count + CNT_W'(1);
            wr_lfsr    <= lfsr_next(wr_lfsr);
            wr_gap_cnt <= wr_gap_q;
          end else if (wr_gap_cnt != 4'd0) begin
            wr_gap_cnt <= wr_gap_cnt - 4'd1;
          end

          if (ren_i) begin
            rd_issued  <= rd_issued + CNT_W'(1);
            rd_gap_cnt <= rd_gap_q;
          end else if (rd_gap_cnt != 4'd0) begin
            rd_gap_cnt <= rd_gap_cnt - 4'd1;
          end

          ren_dly <= {ren_dly[2:0], ren_i};

          if (chk) begin
            rd_count <= rd_count + CNT_W'(1);
            exp_lfsr <= lfsr_next(exp_lfsr);
            if (fifo.rdata != exp_word) begin
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (err_count == '0) first_err_idx <= rd_count;
            end
          end

          if (wen_i || ren_i) wd_cnt <= 32'(TIMEOUT - 1);
          else if (wd_cnt != 32'd0) wd_cnt <= wd_cnt - 32'd1;

          // Normal completion wins over a coincident watchdog expiry.
          if (last_chk || rd_count == num_q) begin
            state   <= S_DONE;
            ren_dly <= '0;
          end else if (wd_fire) begin
            state     <= S_DONE;
            timeout_q <= 1'b1;
            ren_dly   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_traffic_checker.sv
// Bench: behavioural FIFO (latency 1) beside the checker, with a scoreboard
// of expected write words built from an independent pattern model.
module tb_fifo_traffic_checker;
  localparam int DW = 128;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] num_words = '0;
  logic [3:0]  wr_gap = '0, rd_gap = '0;
  logic        busy, done, pass, timeout;
  logic [31:0] wr_count, rd_count, err_count, first_err_idx;

  fifo_traffic_checker_if #(.DW(DW)) fif ();

  fifo_traffic_checker #(.DW(DW), .CNT_W(32), .RD_LAT(1), .TIMEOUT(64), .SEED(32'h1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .num_words(num_words),
    .wr_gap(wr_gap), .rd_gap(rd_gap), .fifo(fif), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .wr_count(wr_count), .rd_count(rd_count),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural FIFO ----------------
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rdata_r = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [DW-1:0] pop_d;
  bit            s_wen = 0, s_ren = 0;
  bit            flush = 0, stuck = 0;
  int            fcount = 0, depth = 8, fault_idx = -1, rd_idx = 0;

  assign fif.full  = (fcount >= depth);
  assign fif.empty = stuck || (fcount == 0);
  assign fif.rdata = rdata_r;

  always @(negedge clk) begin
    s_wen   = fif.wen;
    s_ren   = fif.ren;
    s_wdata = fif.wdata;
  end

  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
      rd_idx = 0;
      fcount <= 0;
    end else begin
      if (s_ren && fq.size() > 0) begin
        pop_d = fq.pop_front();
        if (rd_idx == fault_idx) pop_d[0] = ~pop_d[0];
        rdata_r <= pop_d;
        rd_idx++;
      end
      if (s_wen) fq.push_back(s_wdata);
      fcount <= fq.size();
    end
  end

  // ---------------- scoreboard and model ----------------
  int            tests_run = 0, tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_first, cap_third;
  int            viol, last_wen_cyc, done_cyc;

  function automatic logic [31:0] model_lfsr(input logic [31:0] l);
    logic fb;
    fb = l[0];
    return {fb, l[31:1]} ^ (fb ? 32'h0020_0003 : 32'h0);
  endfunction

  function automatic logic [DW-1:0] model_word(input bit m, input int n, input logic [31:0] l);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++)
      w[k*32 +: 32] = m ? (l ^ 32'(k)) : 32'(n + k);
    return w;
  endfunction

  task automatic start_run(input bit m, input int n, input int wg, input int rg,
                           input int dep, input int fidx, input bit stk);
    logic [31:0] l;
    mode = m; num_words = 32'(n); wr_gap = 4'(wg); rd_gap = 4'(rg);
    depth = dep; fault_idx = fidx; stuck = stk;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    exp_q.delete();
    l = 32'h1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_word(m, i, l));
      l = model_lfsr(l);
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Steps the run cycle by cycle until done, scoring every write.
  task automatic run_wait(input int budget, input int poke_cyc);
    logic [DW-1:0] e;
    int widx;
    bit got;
    widx = 0; got = 0; viol = 0; last_wen_cyc = -1; done_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      if (done) begin got = 1; done_cyc = c; break; end
      if (fif.wen) begin
        last_wen_cyc = c;
        if (widx == 0) cap_first = fif.wdata;
        if (widx == 3) cap_third = fif.wdata;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL wdata_extra idx %0d: got %h, required no write", widx, fif.wdata);
        end else begin
          e = exp_q.pop_front();
          if (fif.wdata !== e) begin
            tests_failed++;
            $display("FAIL wdata idx %0d: got %h, required %h", widx, fif.wdata, e);
          end
        end
        widx++;
      end
      if ((fif.wen && fif.full) || (fif.ren && fif.empty)) viol++;
      if (c == poke_cyc) begin start = 1; num_words = 32'd5; end
      else start = 0;
      @(posedge clk); #1;
    end
    start = 0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL run_done: done not seen within %0d cycles, required done=1", budget);
    end
  endtask

  task automatic check_end(input string nm, input bit x_pass, input int x_wr, input int x_rd,
                           input int x_err);
    tests_run++;
    if ({done, pass} !== {1'b1, x_pass}) begin
      tests_failed++;
      $display("FAIL %s done/pass: got %b%b, required 1%b", nm, done, pass, x_pass);
    end
    tests_run++;
    if (wr_count !== 32'(x_wr) || rd_count !== 32'(x_rd) || err_count !== 32'(x_err)) begin
      tests_failed++;
      $display("FAIL %s counts wr/rd/err: got %0d/%0d/%0d, required %0d/%0d/%0d",
               nm, wr_count, rd_count, err_count, x_wr, x_rd, x_err);
    end
    tests_run++;
    if (viol !== 0) begin
      tests_failed++;
      $display("FAIL %s handshake: got %0d wen-on-full/ren-on-empty cycles, required 0", nm, viol);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done, pass, timeout, fif.wen, fif.ren} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 000000",
               {busy, done, pass, timeout, fif.wen, fif.ren});
    end
    tests_run++;
    if ({wr_count, rd_count, err_count, first_err_idx} !== 128'b0) begin
      tests_failed++;
      $display("FAIL reset_counters: got %h, required 0",
               {wr_count, rd_count, err_count, first_err_idx});
    end
    tests_run++;
    if (fif.wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_wdata: got %h, required 0", fif.wdata);
    end
  endtask

  task automatic test_zero_words();
    start_run(0, 0, 0, 0, 8, -1, 0);
    tests_run++;
    if ({done, pass, busy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL zero_words done/pass/busy: got %b, required 110", {done, pass, busy});
    end
  endtask

  task automatic test_counter();
    start_run(0, 16, 0, 0, 8, -1, 0);
    run_wait(500, -1);
    check_end("counter", 1, 16, 16, 0);
    tests_run++;
    if (cap_third[63:32] !== 32'h4) begin
      tests_failed++;
      $display("FAIL counter_word3_lane1: got %h, required 00000004", cap_third[63:32]);
    end
  endtask

  task automatic test_lfsr();
    start_run(1, 1000, 0, 0, 8, -1, 0);
    run_wait(5000, -1);
    check_end("lfsr", 1, 1000, 1000, 0);
    tests_run++;
    if (cap_first[31:0] !== 32'h1 || cap_first[95:64] !== 32'h3) begin
      tests_failed++;
      $display("FAIL lfsr_first_lanes: got lane0 %h lane2 %h, required 00000001 00000003",
               cap_first[31:0], cap_first[95:64]);
    end
  endtask

  task automatic test_fault();
    start_run(0, 16, 0, 0, 8, 5, 0);
    run_wait(500, -1);
    check_end("fault", 0, 16, 16, 1);
    tests_run++;
    if (first_err_idx !== 32'd5) begin
      tests_failed++;
      $display("FAIL fault_first_err_idx: got %0d, required 5", first_err_idx);
    end
  endtask

  task automatic test_throttle();
    start_run(1, 40, 0, 3, 4, -1, 0);
    run_wait(2000, -1);
    check_end("throttle", 1, 40, 40, 0);
  endtask

  task automatic test_stuck();
    start_run(0, 16, 0, 0, 8, -1, 1);
    run_wait(1000, -1);
    check_end("stuck", 0, 8, 0, 0);
    tests_run++;
    if (timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck_timeout: got %b, required 1", timeout);
    end
    tests_run++;
    if (done_cyc - last_wen_cyc < 62 || done_cyc - last_wen_cyc > 68) begin
      tests_failed++;
      $display("FAIL stuck_latency: got %0d cycles after last write, required about 65",
               done_cyc - last_wen_cyc);
    end
  endtask

  task automatic test_start_ignored();
    start_run(0, 32, 0, 3, 8, -1, 0);
    run_wait(2000, 10);
    check_end("start_in_run", 1, 32, 32, 0);
  endtask

  task automatic test_reset_midrun();
    start_run(0, 64, 1, 1, 8, -1, 0);
    repeat (12) @(posedge clk);
    #1;
    rstn = 0;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done, pass, timeout, fif.wen, fif.ren} !== 6'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset_flags: got %b, required 000000",
               {busy, done, pass, timeout, fif.wen, fif.ren});
    end
    tests_run++;
    if ({wr_count, rd_count, err_count, fif.wdata} !== '0) begin
      tests_failed++;
      $display("FAIL midrun_reset_counters: got wr %0d rd %0d err %0d wdata %h, required 0",
               wr_count, rd_count, err_count, fif.wdata);
    end
    rstn = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_zero_words();
    test_counter();
    test_lfsr();
    test_fault();
    test_throttle();
    test_stuck();
    test_start_ignored();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
